// File: rtl/serial_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// serial_cmp_ctrl
//
// Bit-serial magnitude comparator with its own sequencer. A start request in
// IDLE captures both operands and the sign mode. The comparator then walks the
// operands MSB-first, one bit per clock, and publishes registered L/E/G flags
// together with a one-cycle done pulse.
//
// Parameters
//   WIDTH       operand width in bits (>= 2)
//   EARLY_EXIT  1: finish as soon as the result is decided
//               0: always run WIDTH bit-steps
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   start      request, sampled only while idle
//   A, B       operands, captured on the accepting edge
//   is_signed  1 = two's-complement compare, captured with the operands
//   busy       high while bit-steps are running
//   done       one-cycle pulse when L/E/G take a new result
//   L, E, G    A < B, A == B, A > B (exactly one is high)
// -----------------------------------------------------------------------------
module serial_cmp_ctrl #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             L,
    output logic             E,
    output logic             G
);

    // The counter must hold the value WIDTH itself, hence the extra bit.
    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_e;

    typedef enum logic [1:0] {
        CMP_EQ,
        CMP_GT,
        CMP_LT
    } cmp_e;

    // Control state
    state_e          state_q, state_d;
    cmp_e            cmp_q,   cmp_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            done_q,  done_d;
    logic            l_q,     l_d;
    logic            e_q,     e_d;
    logic            g_q,     g_d;

    // Datapath state
    logic [WIDTH-1:0] sa_q,  sa_d;
    logic [WIDTH-1:0] sb_q,  sb_d;
    logic             sgn_q, sgn_d;

    logic bit_a;
    logic bit_b;
    logic finish;

    assign bit_a = sa_q[WIDTH-1];
    assign bit_b = sb_q[WIDTH-1];

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; that is what keeps this block free of latches.
        state_d = state_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        l_d     = l_q;
        e_d     = e_q;
        g_d     = g_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sgn_d   = sgn_q;
        finish  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Flags are deliberately left alone here: they keep the last
                // result until the next operation finishes.
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    sgn_d   = is_signed;
                    cmp_d   = CMP_EQ;
                    cnt_d   = CNT_FULL;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                // The first differing bit decides; later bits cannot change
                // the outcome. In signed mode the MSB is the sign bit, so a 1
                // there means the smaller value.
                if (cmp_q == CMP_EQ && bit_a != bit_b) begin
                    if (sgn_q && cnt_q == CNT_FULL) begin
                        cmp_d = bit_a ? CMP_LT : CMP_GT;
                    end else begin
                        cmp_d = bit_a ? CMP_GT : CMP_LT;
                    end
                end

                sa_d  = {sa_q[WIDTH-2:0], 1'b0};
                sb_d  = {sb_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNT_LAST;

                finish = (cnt_q == CNT_LAST) || (EARLY_EXIT && cmp_d != CMP_EQ);

                if (finish) begin
                    l_d     = (cmp_d == CMP_LT);
                    e_d     = (cmp_d == CMP_EQ);
                    g_d     = (cmp_d == CMP_GT);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cmp_q   <= CMP_EQ;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            l_q     <= 1'b0;
            e_q     <= 1'b1;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            l_q     <= l_d;
            e_q     <= e_d;
            g_q     <= g_d;
        end
    end

    // NOTE: the operand shift registers and sign mode are not reset; they are
    // always loaded on accept before being read, so a reset would only cost
    // routing and buy nothing.
    always_ff @(posedge clk) begin
        sa_q  <= sa_d;
        sb_q  <= sb_d;
        sgn_q <= sgn_d;
    end

    assign busy = (state_q == S_SHIFT);
    assign done = done_q;
    assign L    = l_q;
    assign E    = e_q;
    assign G    = g_q;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_cmp_ctrl
//
// Two comparators share clock and reset: index 0 runs all WIDTH steps, index 1
// exits early. Stimulus pushes the hand-computed result {L,E,G}, latency and
// accept cycle into a per-instance queue; a monitor on the falling edge pops
// an entry on every done pulse and compares flags, latency and busy length.
// Between done pulses the monitor also holds the flags to their last result.
// -----------------------------------------------------------------------------
module tb_serial_cmp_ctrl;

    localparam int W = 32;

    typedef struct {
        logic [2:0] leg;   // {L,E,G}
        int         lat;
        int         acc;   // cycle number of the accepting edge
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_i [2];
    logic [W-1:0] a_i     [2];
    logic [W-1:0] b_i     [2];
    logic         sgn_i   [2];
    logic         busy_o  [2];
    logic         done_o  [2];
    logic         l_o     [2];
    logic         e_o     [2];
    logic         g_o     [2];

    exp_t         sb [2][$];
    int           cyc = 0;
    int           n_checks = 0;
    int           errors = 0;
    int           busy_cnt [2];
    logic [2:0]   last_leg [2];
    logic         prev_done [2];
    exp_t         mon_ex;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_cmp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .reset(reset), .start(start_i[0]), .A(a_i[0]), .B(b_i[0]),
        .is_signed(sgn_i[0]), .busy(busy_o[0]), .done(done_o[0]),
        .L(l_o[0]), .E(e_o[0]), .G(g_o[0])
    );

    serial_cmp_ctrl #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_early (
        .clk(clk), .reset(reset), .start(start_i[1]), .A(a_i[1]), .B(b_i[1]),
        .is_signed(sgn_i[1]), .busy(busy_o[1]), .done(done_o[1]),
        .L(l_o[1]), .E(e_o[1]), .G(g_o[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    // Called in the "posedge + 1" phase. Waits for the instance to be idle,
    // presents the request and returns just after the accepting edge.
    task automatic issue(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2:0] leg, input int lat, input bit hold);
        int guard = 0;
        while (busy_o[d] && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (busy_o[d]) begin
            check($sformatf("dut%0d_idle_before_issue", d), busy_o[d], 0);
            return;
        end
        start_i[d] = 1'b1;
        a_i[d]     = a;
        b_i[d]     = b;
        sgn_i[d]   = s;
        sb[d].push_back('{leg: leg, lat: lat, acc: cyc + 1});
        @(posedge clk); #1;
        if (!hold) start_i[d] = 1'b0;
    endtask

    task automatic drain(input int d);
        int guard = 0;
        while (sb[d].size() != 0 && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("dut%0d_drain_pending", d), sb[d].size(), 0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                busy_cnt[d] = 0;
                last_leg[d] = 3'b010;
            end else begin
                if (busy_o[d]) busy_cnt[d]++;
                if (done_o[d]) begin
                    check($sformatf("dut%0d_done_width", d), prev_done[d], 0);
                    check($sformatf("dut%0d_busy_low_at_done", d), busy_o[d], 0);
                    if (sb[d].size() == 0) begin
                        n_checks++;
                        errors++;
                        $display("FAIL dut%0d_unexpected_done: got done at cycle %0d want no done", d, cyc);
                    end else begin
                        mon_ex = sb[d].pop_front();
                        check($sformatf("dut%0d_flags", d), {l_o[d], e_o[d], g_o[d]}, mon_ex.leg);
                        check($sformatf("dut%0d_latency", d), cyc - mon_ex.acc, mon_ex.lat);
                        check($sformatf("dut%0d_busy_cycles", d), busy_cnt[d], mon_ex.lat);
                        last_leg[d] = mon_ex.leg;
                    end
                    busy_cnt[d] = 0;
                end else begin
                    check($sformatf("dut%0d_flags_stable", d), {l_o[d], e_o[d], g_o[d]}, last_leg[d]);
                end
            end
            prev_done[d] = done_o[d];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout at cycle %0d want normal end", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_i[d]   = 1'b0;
            a_i[d]       = '0;
            b_i[d]       = '0;
            sgn_i[d]     = 1'b0;
            busy_cnt[d]  = 0;
            last_leg[d]  = 3'b010;
            prev_done[d] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_rst_busy", d), busy_o[d], 0);
            check($sformatf("dut%0d_rst_done", d), done_o[d], 0);
            check($sformatf("dut%0d_rst_flags", d), {l_o[d], e_o[d], g_o[d]}, 3'b010);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(2);

        // Full-length run: 5 < 9 unsigned, no early exit
        issue(0, 32'd5, 32'd9, 1'b0, 3'b100, 32, 1'b0);
        drain(0);

        // Equal operands with early exit enabled still take WIDTH steps
        issue(1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b010, 32, 1'b0);
        drain(1);
        issue(1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 3'b010, 32, 1'b0);
        drain(1);

        // MSB decides: unsigned greater, signed less
        issue(1, 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b001, 1, 1'b0);
        drain(1);
        issue(1, 32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b100, 1, 1'b0);
        drain(1);

        // -2 < -1 signed, decided on the last bit; start pokes while busy
        issue(1, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3'b100, 32, 1'b0);
        for (int i = 0; i < 10; i++) begin
            start_i[1] = 1'b1;
            a_i[1]     = 32'd1;
            b_i[1]     = 32'd0;
            sgn_i[1]   = 1'b0;
            @(posedge clk); #1;
        end
        start_i[1] = 1'b0;
        drain(1);
        idle_cycles(5);

        // Reset ten cycles into an operation aborts it
        issue(0, 32'd5, 32'd9, 1'b0, 3'b100, 32, 1'b0);
        idle_cycles(9);
        reset = 1'b0;
        @(posedge clk); #1;
        sb[0].delete();
        @(negedge clk);
        check("dut0_abort_busy", busy_o[0], 0);
        check("dut0_abort_done", done_o[0], 0);
        check("dut0_abort_flags", {l_o[0], e_o[0], g_o[0]}, 3'b010);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(40);
        issue(0, 32'd9, 32'd5, 1'b0, 3'b001, 32, 1'b0);
        drain(0);

        // start held high: back-to-back operations, latency+1 apart
        issue(1, 32'h40000000, 32'h00000000, 1'b0, 3'b001, 2, 1'b1);
        issue(1, 32'h00000001, 32'h00000003, 1'b0, 3'b100, 31, 1'b1);
        issue(1, 32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b100, 1, 1'b0);
        drain(1);
        idle_cycles(5);

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_cmp_ctrl.md
# serial_cmp_ctrl

Bit-serial magnitude comparator with its own sequencer. It accepts a pair of WIDTH-bit operands through a start/busy/done handshake and loads them into internal shift registers. It then steps an MSB-first compare FSM one bit per clock and publishes registered L/E/G flags. It is the controlled, handshake-driven replacement for free-running serial comparison in the arithmetic datapath, and adds a signed mode and optional early termination.

## Interface
- WIDTH, 32, operand width in bits; legal range WIDTH ≥ 2
- EARLY_EXIT, 1, 1 = finish as soon as the result is decided; 0 = always run WIDTH bit-steps
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  operand A; captured on the accepting edge
- B  input  WIDTH  operand B; captured on the accepting edge
- is_signed  input  1  1 = two's-complement compare; captured with the operands
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when L/E/G become valid
- L  output  1  A < B
- E  output  1  A == B
- G  output  1  A > B

## Operation
- Internal state:
  - control FSM {IDLE, SHIFT}
  - shift registers sa, sb (WIDTH bits each)
  - captured sign mode
  - bit counter, ceil(log2(WIDTH))+1 bits
  - compare state {EQ, GT, LT}
  - result registers L/E/G
- IDLE, with start=1: capture A→sa and B→sb, capture is_signed, compare state←EQ, counter←WIDTH, go to SHIFT. L/E/G keep their previous values.
- SHIFT, each edge, with a=sa[WIDTH-1] and b=sb[WIDTH-1]:
  - Compare state EQ and a≠b:
    - first bit (counter==WIDTH) in signed mode: a=1 gives LT, a=0 gives GT.
    - any other bit, or unsigned mode: a=1 gives GT, a=0 gives LT.
  - Compare state GT or LT: hold (the decision is sticky).
  - Shift sa and sb left by one, zero fill. Decrement counter.
  - Finish when counter==1 before the decrement (last bit), or when EARLY_EXIT=1 and the next compare state ≠ EQ.
  - On finish: load L/E/G from the next compare state (exactly one set), pulse done, go to IDLE.
- start is ignored while busy. Operand and is_signed changes while busy do not affect the running operation.
- Exactly one of L/E/G is high at all times after reset.

## Timing
- Reset (reset=0 at an edge): FSM←IDLE, busy=0, done=0, L=0, E=1, G=0, compare state←EQ. Reset takes priority over every other event.
- Reset mid-operation aborts with no done pulse, and flags return to E=1.
- Accept edge t0. busy is high from the cycle after t0.
- Latency, EARLY_EXIT=0: always WIDTH cycles. done and valid flags appear in the cycle after edge t0+WIDTH, and busy is low in that same cycle.
- Latency, EARLY_EXIT=1: k cycles, where k is the 1-based position (from the MSB) of the first differing bit. Equal operands take WIDTH cycles.
- done is high for exactly one cycle. The done cycle is an IDLE cycle: if start=1 there, the next operation is accepted at the following edge. Throughput with start held high is one result per latency+1 cycles.
- Flags are registered, with no combinational path from A/B/start to L/E/G/busy/done.
- Flags stay stable from the done cycle until the next finish or reset. They are not cleared on accept.

## Test plan
- Reset, then A=5, B=9, unsigned, EARLY_EXIT=0 → busy for 32 cycles, done pulse in cycle 33 after the accept edge, L=1/E=0/G=0.
- A=B=32'hDEADBEEF, EARLY_EXIT=1, signed and unsigned → done after 32 cycles in both modes, E=1.
- EARLY_EXIT=1, A=32'h80000000, B=32'h7FFFFFFF:
  - unsigned → done in the cycle after the first step (latency 1), G=1.
  - is_signed=1 → same latency, L=1.
- A=32'hFFFFFFFE, B=32'hFFFFFFFF, signed, EARLY_EXIT=1 → latency 32, L=1. Assert start with different operands during busy → result unaffected, no extra done.
- Start a compare, then drive reset=0 at cycle 10 → next cycle busy=0, done=0, E=1, no done pulse afterwards. A new start then completes normally.
- start held high continuously, 3 operand pairs presented on successive accepts → 3 done pulses, each separated by latency+1 cycles, with correct flags for each pair.
